// File: rtl/reset_ctrl_pkg.sv
// rtl/reset_ctrl_pkg.sv - shared types and constants for the reset controller
// Contents: FSM state enum, default parameter values, Reset_Count width.
package reset_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2
    } rc_state_t;

    localparam int RC_SYNC_STAGES_DEF     = 2;
    localparam int RC_DEBOUNCE_CYCLES_DEF = 400000;
    localparam int RC_HOLD_CYCLES_DEF     = 16;
    localparam int RC_COUNT_W             = 8;

endpackage

// File: rtl/reset_controller_if.sv
// rtl/reset_controller_if.sv - switch/core-reset signal bundle of the reset controller
// Signals: SW_In (raw run switch), RST_Core, SW_Debounced, Reset_Count[7:0], Run_LED.
// master: the reset controller side; slave: the board/core side.
interface reset_controller_if;
    import reset_ctrl_pkg::*;

    logic                  SW_In;
    logic                  RST_Core;
    logic                  SW_Debounced;
    logic [RC_COUNT_W-1:0] Reset_Count;
    logic                  Run_LED;

    modport master (
        input  SW_In,
        output RST_Core,
        output SW_Debounced,
        output Reset_Count,
        output Run_LED
    );

    modport slave (
        output SW_In,
        input  RST_Core,
        input  SW_Debounced,
        input  Reset_Count,
        input  Run_LED
    );
endinterface

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - synchroniser and debounce counter for the run switch
// Ports: i_clk, i_rst (async active-high), i_sw (raw switch), o_sw_debounced.
module switch_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 400000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sw,
    output logic o_sw_debounced
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_sw_debounced;
    logic                   w_sync_sw;

    assign w_sync_sw      = r_sync[SYNC_STAGES-1];
    assign o_sw_debounced = r_sw_debounced;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync         <= '0;
            r_cnt          <= '0;
            r_sw_debounced <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sw};
            // A level is accepted only after DEBOUNCE_CYCLES consecutive
            // mismatching samples; any agreeing sample restarts the run.
            if (w_sync_sw == r_sw_debounced) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_sw_debounced <= w_sync_sw;
                r_cnt          <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/reset_controller.sv
// rtl/reset_controller.sv - debounced run switch to registered core reset sequencer
// Ports: CLK, RST (async active-high, from !locked), bus (reset_controller_if.master):
//   SW_In in, RST_Core / SW_Debounced / Reset_Count / Run_LED out.
module reset_controller
    import reset_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES     = RC_SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = RC_DEBOUNCE_CYCLES_DEF,
    parameter int HOLD_CYCLES     = RC_HOLD_CYCLES_DEF
) (
    input  logic                CLK,
    input  logic                RST,
    reset_controller_if.master  bus
);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [RC_COUNT_W-1:0] COUNT_MAX = '1;

    logic                  w_sw_debounced;
    rc_state_t             r_state;
    logic [HOLD_W-1:0]     r_hold_cnt;
    logic                  r_rst_core;
    logic                  r_run_led;
    logic [RC_COUNT_W-1:0] r_reset_count;

    switch_debouncer #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .i_clk          (CLK),
        .i_rst          (RST),
        .i_sw           (bus.SW_In),
        .o_sw_debounced (w_sw_debounced)
    );

    assign bus.SW_Debounced = w_sw_debounced;
    assign bus.RST_Core     = r_rst_core;
    assign bus.Run_LED      = r_run_led;
    assign bus.Reset_Count  = r_reset_count;

    // Outputs are loaded with the value belonging to the next state on the
    // same edge as r_state, so RST_Core changes exactly on RUN entry/exit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state       <= IDLE;
            r_hold_cnt    <= '0;
            r_rst_core    <= 1'b1;
            r_run_led     <= 1'b0;
            r_reset_count <= '0;
        end else begin
            r_rst_core <= 1'b1;
            r_run_led  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_sw_debounced) begin
                        r_state    <= HOLD;
                        r_hold_cnt <= '0;
                    end
                end
                HOLD: begin
                    if (!w_sw_debounced) begin
                        r_state <= IDLE;
                    end else if (r_hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                        r_state    <= RUN;
                        r_rst_core <= 1'b0;
                        r_run_led  <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!w_sw_debounced) begin
                        r_state <= IDLE;
                        if (r_reset_count != COUNT_MAX) begin
                            r_reset_count <= r_reset_count + 1'b1;
                        end
                    end else begin
                        r_rst_core <= 1'b0;
                        r_run_led  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reset_controller.sv
// tb/tb_reset_controller.sv - self-checking bench for reset_controller
module tb_reset_controller;
    logic CLK = 1'b0;
    logic RST;
    logic RST_H;

    reset_controller_if bus();
    reset_controller_if bus_h();

    reset_controller #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(3)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Longer hold so a debounced switch drop can land inside HOLD.
    reset_controller #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8)
    ) dut_h (
        .CLK (CLK),
        .RST (RST_H),
        .bus (bus_h)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic sw;
        logic rst_core;
        logic deb;
        logic led;
    } vec_t;

    vec_t vecs[19];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_vec(input int i, input logic sw, input logic rc, input logic deb, input logic led);
        vecs[i].sw       = sw;
        vecs[i].rst_core = rc;
        vecs[i].deb      = deb;
        vecs[i].led      = led;
    endtask

    task automatic wait_core(input logic val, input string name);
        int k;
        k = 0;
        while (bus.RST_Core !== val && k < 100) begin
            @(posedge CLK); #1;
            k++;
        end
        chk(name, int'(bus.RST_Core), int'(val));
    endtask

    initial begin
        // edges 1..11 of power-up, then a 3-cycle glitch while in RUN
        for (int i = 0; i < 5; i++) set_vec(i, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 5; i < 9; i++) set_vec(i, 1'b1, 1'b1, 1'b1, 1'b0);
        set_vec(9,  1'b1, 1'b0, 1'b1, 1'b1);
        set_vec(10, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 11; i < 14; i++) set_vec(i, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 14; i < 19; i++) set_vec(i, 1'b1, 1'b0, 1'b1, 1'b1);

        RST = 1'b1;
        RST_H = 1'b1;
        bus.SW_In = 1'b1;
        bus_h.SW_In = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset RST_Core", int'(bus.RST_Core), 1);
        chk("reset SW_Debounced", int'(bus.SW_Debounced), 0);
        chk("reset Run_LED", int'(bus.Run_LED), 0);
        chk("reset Reset_Count", int'(bus.Reset_Count), 0);
        RST = 1'b0;

        // Power-up and glitch rejection
        for (int i = 0; i < 19; i++) begin
            bus.SW_In = vecs[i].sw;
            @(posedge CLK); #1;
            chk($sformatf("vec%0d RST_Core", i), int'(bus.RST_Core), int'(vecs[i].rst_core));
            chk($sformatf("vec%0d SW_Debounced", i), int'(bus.SW_Debounced), int'(vecs[i].deb));
            chk($sformatf("vec%0d Run_LED", i), int'(bus.Run_LED), int'(vecs[i].led));
            chk($sformatf("vec%0d Reset_Count", i), int'(bus.Reset_Count), 0);
        end

        // User reset: RST_Core asserts exactly 7 edges after SW_In falls
        bus.SW_In = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            @(posedge CLK); #1;
            chk($sformatf("user reset edge%0d RST_Core", e), int'(bus.RST_Core), (e < 7) ? 0 : 1);
        end
        chk("user reset Reset_Count", int'(bus.Reset_Count), 1);
        chk("user reset Run_LED", int'(bus.Run_LED), 0);
        bus.SW_In = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge CLK); #1;
            chk($sformatf("rerun edge%0d RST_Core", e), int'(bus.RST_Core), (e < 10) ? 1 : 0);
        end

        // Saturation: resets 2..257
        for (int i = 2; i <= 257; i++) begin
            bus.SW_In = 1'b0;
            wait_core(1'b1, $sformatf("sat%0d assert", i));
            chk($sformatf("sat%0d Reset_Count", i), int'(bus.Reset_Count), (i > 255) ? 255 : i);
            bus.SW_In = 1'b1;
            wait_core(1'b0, $sformatf("sat%0d release", i));
        end

        // Async reset between edges while in RUN
        #3;
        RST = 1'b1;
        #1;
        chk("async RST_Core", int'(bus.RST_Core), 1);
        chk("async Reset_Count", int'(bus.Reset_Count), 0);
        chk("async Run_LED", int'(bus.Run_LED), 0);
        chk("async SW_Debounced", int'(bus.SW_Debounced), 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge CLK); #1;
            chk($sformatf("post-async edge%0d RST_Core", e), int'(bus.RST_Core), (e < 10) ? 1 : 0);
        end
        chk("post-async Reset_Count", int'(bus.Reset_Count), 0);

        // Abort during HOLD on the long-hold instance
        RST_H = 1'b0;
        for (int e = 1; e <= 24; e++) begin
            @(posedge CLK); #1;
            chk($sformatf("abort edge%0d RST_Core", e), int'(bus_h.RST_Core), 1);
            chk($sformatf("abort edge%0d SW_Debounced", e), int'(bus_h.SW_Debounced),
                (e >= 6 && e < 12) ? 1 : 0);
            if (e == 6) bus_h.SW_In = 1'b0;
        end
        chk("abort Run_LED", int'(bus_h.Run_LED), 0);
        chk("abort Reset_Count", int'(bus_h.Reset_Count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
